// File: rtl/mod_counter_chain.sv
// Cascade of DIGITS modulo-MODULUS counters with up/down, clamped load, wrap/saturate and sticky ovf.
// data/ovf registered (one clk); cout/zero combinational. No backpressure: ce steps once per enabled clk.
module mod_counter_chain #(
    parameter int DIGITS  = 4,
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10,
    parameter int WRAP    = 1
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    ce,
    input  logic                    up,
    input  logic                    load,
    input  logic [DIGITS*WIDTH-1:0] load_data,
    output logic [DIGITS*WIDTH-1:0] data,
    output logic                    cout,
    output logic                    zero,
    output logic                    ovf
);

    localparam logic [WIDTH-1:0] MAX_DIG = WIDTH'(MODULUS - 1);
    localparam bit               SAT     = (WRAP == 0);

    if (MODULUS > 2**WIDTH || MODULUS < 2) begin : g_bad_param
        $error("mod_counter_chain: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    logic [DIGITS*WIDTH-1:0] r_data;
    logic                    r_ovf;

    // w_lo_max[k] / w_lo_zero[k]: every digit below k sits at MODULUS-1 / 0
    logic [DIGITS:0]         w_lo_max;
    logic [DIGITS:0]         w_lo_zero;
    logic [DIGITS*WIDTH-1:0] w_step_val;
    logic [DIGITS*WIDTH-1:0] w_load_val;
    logic                    w_term;

    assign w_lo_max[0]  = 1'b1;
    assign w_lo_zero[0] = 1'b1;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [WIDTH-1:0] w_dig;
        logic [WIDTH-1:0] w_ld;
        logic [WIDTH-1:0] w_inc;
        logic [WIDTH-1:0] w_dec;
        logic             w_step;

        assign w_dig  = r_data[k*WIDTH +: WIDTH];
        assign w_ld   = load_data[k*WIDTH +: WIDTH];
        assign w_inc  = (w_dig == MAX_DIG) ? '0 : w_dig + WIDTH'(1);
        assign w_dec  = (w_dig == '0) ? MAX_DIG : w_dig - WIDTH'(1);
        assign w_step = up ? w_lo_max[k] : w_lo_zero[k];

        assign w_lo_max[k+1]  = w_lo_max[k] & (w_dig == MAX_DIG);
        assign w_lo_zero[k+1] = w_lo_zero[k] & (w_dig == '0);

        assign w_step_val[k*WIDTH +: WIDTH] = !w_step ? w_dig : (up ? w_inc : w_dec);
        assign w_load_val[k*WIDTH +: WIDTH] = (w_ld > MAX_DIG) ? MAX_DIG : w_ld;
    end

    assign w_term = up ? w_lo_max[DIGITS] : w_lo_zero[DIGITS];

    always_ff @(posedge clk) begin
        if (clr) begin
            r_data <= '0;
            r_ovf  <= 1'b0;
        end else if (load) begin
            r_data <= w_load_val;
            r_ovf  <= 1'b0;
        end else if (ce) begin
            if (w_term) begin
                r_ovf <= 1'b1;
            end
            // Saturating chain parks at the terminal state; wrapping chain rolls over
            if (!(SAT && w_term)) begin
                r_data <= w_step_val;
            end
        end
    end

    assign data = r_data;
    assign ovf  = r_ovf;
    assign cout = ce & w_term;
    assign zero = w_lo_zero[DIGITS];

endmodule

// File: tb/tb_mod_counter_chain.sv
// Bench for mod_counter_chain: directed vector table, saturate sequence, and randomized run vs a value-level model.
module tb_mod_counter_chain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr = 1'b0, ce = 1'b0, up = 1'b1, load = 1'b0;
    logic [7:0] ld   = '0;
    logic [8:0] ld_o = '0;

    logic [7:0] data_w, data_s;
    logic [8:0] data_o;
    logic       cout_w, cout_s, cout_o;
    logic       zero_w, zero_s, zero_o;
    logic       ovf_w, ovf_s, ovf_o;
    logic       pc_w, pc_s, pc_o;

    mod_counter_chain #(.DIGITS(2), .WIDTH(4), .MODULUS(10), .WRAP(1)) u_wrap (
        .clk(clk), .clr(clr), .ce(ce), .up(up), .load(load), .load_data(ld),
        .data(data_w), .cout(cout_w), .zero(zero_w), .ovf(ovf_w));

    mod_counter_chain #(.DIGITS(2), .WIDTH(4), .MODULUS(10), .WRAP(0)) u_sat (
        .clk(clk), .clr(clr), .ce(ce), .up(up), .load(load), .load_data(ld),
        .data(data_s), .cout(cout_s), .zero(zero_s), .ovf(ovf_s));

    mod_counter_chain #(.DIGITS(3), .WIDTH(3), .MODULUS(6), .WRAP(1)) u_odd (
        .clk(clk), .clr(clr), .ce(ce), .up(up), .load(load), .load_data(ld_o),
        .data(data_o), .cout(cout_o), .zero(zero_o), .ovf(ovf_o));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Drive at negedge, capture combinational cout before the edge, return just after the edge.
    task automatic cyc(input logic c, input logic e, input logic u, input logic l,
                       input logic [7:0] d, input logic [8:0] dd);
        @(negedge clk);
        clr = c; ce = e; up = u; load = l; ld = d; ld_o = dd;
        #1;
        pc_w = cout_w; pc_s = cout_s; pc_o = cout_o;
        @(posedge clk);
        #2;
    endtask

    typedef struct {
        logic       clr, ce, up, load;
        logic [7:0] ld;
        logic       ecout;
        logic [7:0] edata;
        logic       ezero, eovf;
    } vec_t;

    function automatic vec_t mk(input logic c, input logic e, input logic u, input logic l,
                                input logic [7:0] d, input logic ec, input logic [7:0] ed,
                                input logic ez, input logic eo);
        vec_t v;
        v.clr = c; v.ce = e; v.up = u; v.load = l; v.ld = d;
        v.ecout = ec; v.edata = ed; v.ezero = ez; v.eovf = eo;
        return v;
    endfunction

    function automatic logic [7:0] bcd(input int i);
        return 8'(((i / 10) << 4) | (i % 10));
    endfunction

    // Reference model: the count is one integer in 0 .. MOD**ND - 1.
    function automatic int pmod(input int d); return (d == 2) ? 6 : 10; endfunction
    function automatic int pwid(input int d); return (d == 2) ? 3 : 4;  endfunction
    function automatic int pnd (input int d); return (d == 2) ? 3 : 2;  endfunction
    function automatic bit pwrap(input int d); return d != 1;           endfunction

    function automatic int ipow(input int b, input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r *= b;
        return r;
    endfunction

    function automatic int mmax(input int d);
        return ipow(pmod(d), pnd(d)) - 1;
    endfunction

    function automatic int mclamp(input int d, input logic [31:0] v);
        int s = 0;
        for (int k = 0; k < pnd(d); k++) begin
            int f;
            f = int'((v >> (k * pwid(d))) & ((32'd1 << pwid(d)) - 1));
            if (f > pmod(d) - 1) f = pmod(d) - 1;
            s += f * ipow(pmod(d), k);
        end
        return s;
    endfunction

    function automatic logic [31:0] mpack(input int d, input int v);
        logic [31:0] r = '0;
        for (int k = 0; k < pnd(d); k++)
            r |= 32'((v / ipow(pmod(d), k)) % pmod(d)) << (k * pwid(d));
        return r;
    endfunction

    function automatic logic [31:0] dut_data(input int d);
        return (d == 0) ? 32'(data_w) : (d == 1) ? 32'(data_s) : 32'(data_o);
    endfunction
    function automatic logic dut_zero(input int d);
        return (d == 0) ? zero_w : (d == 1) ? zero_s : zero_o;
    endfunction
    function automatic logic dut_ovf(input int d);
        return (d == 0) ? ovf_w : (d == 1) ? ovf_s : ovf_o;
    endfunction
    function automatic logic dut_pc(input int d);
        return (d == 0) ? pc_w : (d == 1) ? pc_s : pc_o;
    endfunction

    vec_t tbl[$];
    int   mv[3];
    bit   mo[3];

    initial begin
        for (int i = 1; i <= 10; i++) tbl.push_back(mk(0, 1, 1, 0, 8'h00, 0, bcd(i), 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 8'h99, 0, 8'h99, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 8'h00, 1, 8'h00, 1, 1));
        for (int i = 1; i <= 5; i++) tbl.push_back(mk(0, 1, 1, 0, 8'h00, 0, bcd(i), 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 8'h00, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h00, 1, 8'h99, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 8'h98, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 8'hAF, 0, 8'h99, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 1, 0, 8'h00, 0, 8'h99, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 8'h55, 0, 8'h55, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 8'h55, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 8'h42, 0, 8'h42, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 8'h41, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 8'h00, 0, 8'h42, 0, 0));

        // Reset state
        cyc(1, 0, 1, 0, 8'h00, 9'h000);
        chk("rst_data", 32'(data_w), 32'h0);
        chk("rst_ovf",  32'(ovf_w),  32'h0);
        chk("rst_zero", 32'(zero_w), 32'h1);
        chk("rst_cout", 32'(cout_w), 32'h0);
        @(negedge clk);
        clr = 1'b0; ce = 1'b1; up = 1'b0;
        #1;
        chk("rst_cout_down", 32'(cout_w), 32'h1);
        ce = 1'b0; up = 1'b1;

        foreach (tbl[i]) begin
            cyc(tbl[i].clr, tbl[i].ce, tbl[i].up, tbl[i].load, tbl[i].ld, 9'h000);
            chk($sformatf("tbl%0d_cout", i), 32'(pc_w),   32'(tbl[i].ecout));
            chk($sformatf("tbl%0d_data", i), 32'(data_w), 32'(tbl[i].edata));
            chk($sformatf("tbl%0d_zero", i), 32'(zero_w), 32'(tbl[i].ezero));
            chk($sformatf("tbl%0d_ovf",  i), 32'(ovf_w),  32'(tbl[i].eovf));
        end

        // Saturating chain parks at the terminal state
        cyc(0, 0, 1, 1, 8'h98, 9'h000);
        chk("sat_load", 32'(data_s), 32'h98);
        chk("sat_load_ovf", 32'(ovf_s), 32'h0);
        for (int j = 0; j < 3; j++) begin
            cyc(0, 1, 1, 0, 8'h00, 9'h000);
            chk($sformatf("sat_up%0d_cout", j), 32'(pc_s),   32'(j > 0));
            chk($sformatf("sat_up%0d_data", j), 32'(data_s), 32'h99);
            chk($sformatf("sat_up%0d_ovf",  j), 32'(ovf_s),  32'(j > 0));
        end
        cyc(0, 0, 1, 1, 8'h00, 9'h000);
        cyc(0, 1, 0, 0, 8'h00, 9'h000);
        chk("sat_dn_cout", 32'(pc_s),   32'h1);
        chk("sat_dn_data", 32'(data_s), 32'h00);
        chk("sat_dn_zero", 32'(zero_s), 32'h1);
        chk("sat_dn_ovf",  32'(ovf_s),  32'h1);

        // Randomized run against the integer model
        cyc(1, 0, 1, 0, 8'h00, 9'h000);
        for (int d = 0; d < 3; d++) begin mv[d] = 0; mo[d] = 0; end
        begin
            logic dir = 1'b1;
            for (int i = 0; i < 3000; i++) begin
                logic        rc, re, rl;
                logic [7:0]  rd;
                logic [8:0]  rdo;
                bit          mc[3];
                rc  = ($urandom_range(0, 63) == 0);
                rl  = ($urandom_range(0, 15) == 0);
                re  = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 24) == 0) dir = ~dir;
                rd  = 8'($urandom);
                rdo = 9'($urandom);
                for (int d = 0; d < 3; d++)
                    mc[d] = re && (dir ? (mv[d] == mmax(d)) : (mv[d] == 0));
                cyc(rc, re, dir, rl, rd, rdo);
                for (int d = 0; d < 3; d++) begin
                    if (rc) begin
                        mv[d] = 0; mo[d] = 0;
                    end else if (rl) begin
                        mv[d] = mclamp(d, (d == 2) ? 32'(rdo) : 32'(rd)); mo[d] = 0;
                    end else if (re) begin
                        if (mc[d]) begin
                            mo[d] = 1;
                            if (pwrap(d)) mv[d] = dir ? 0 : mmax(d);
                        end else begin
                            mv[d] = dir ? mv[d] + 1 : mv[d] - 1;
                        end
                    end
                    chk($sformatf("rnd%0d_d%0d_cout", i, d), 32'(dut_pc(d)),   32'(mc[d]));
                    chk($sformatf("rnd%0d_d%0d_data", i, d), dut_data(d),      mpack(d, mv[d]));
                    chk($sformatf("rnd%0d_d%0d_zero", i, d), 32'(dut_zero(d)), 32'(mv[d] == 0));
                    chk($sformatf("rnd%0d_d%0d_ovf",  i, d), 32'(dut_ovf(d)),  32'(mo[d]));
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
